sakebi_rmii_rx_stream: RTL and testbench
========================================

Name: sakebi_rmii_rx_stream

Overview:
- Single-clock RMII receiver that runs entirely in the REF_CLK domain. Supports 10 and 100 Mb/s.
- Strips preamble/SFD, packs bytes into a DATA_WIDTH AXI-Stream, and frames each packet with TLAST/TKEEP.
- Checks FCS, minimum length and byte alignment, and reports the result on TUSER of the final beat.
- An internal FIFO absorbs downstream backpressure. On overflow the frame is cut short and flagged, never silently truncated.

Parameters:
DATA_WIDTH, 8, stream width in bits; legal values 8/16/32.
FIFO_DEPTH, 16, beat entries in output FIFO; power of two, >=4.
MIN_FRAME, 64, minimum byte count after SFD (FCS included); shorter frames are errored.
DIV_10M, 10, REF_CLK cycles per dibit in 10 Mb/s mode.

Ports:
i_rmii_REF_CLK  in  1  sole clock, 50 MHz
i_rmii_RESET  in  1  synchronous active-high reset
i_speed_100  in  1  1=100 Mb/s, 0=10 Mb/s; changed only while idle
i_rmii_CRS_DV  in  1  carrier sense / data valid
i_rmii_RXD  in  2  receive dibit
o_axis_TVALID  out  1  beat valid
i_axis_TREADY  in  1  sink ready
o_axis_TDATA  out  DATA_WIDTH  payload; first byte of the beat in lane 0 [7:0]
o_axis_TKEEP  out  DATA_WIDTH/8  valid byte lanes
o_axis_TLAST  out  1  final beat of frame
o_axis_TUSER  out  1  on TLAST beat: 1 = frame bad
o_frame_ok  out  1  1-cycle pulse, good frame ended
o_frame_err  out  1  1-cycle pulse, bad frame ended
o_overflow  out  1  1-cycle pulse, FIFO overflow cut a frame

Behaviour:
- Clock and reset: one clock, i_rmii_REF_CLK. Reset is synchronous and active-high on i_rmii_RESET.
- Reset values: all outputs 0; FIFO emptied; pending word cleared; state IDLE.
  - Reset mid-frame discards the FIFO and the partial frame.
  - After reset, IDLE only accepts a carrier once CRS_DV has been sampled low.
- Input capture: CRS_DV and RXD are registered once.
- Sample strobe:
  - 100M mode: strobe every cycle.
  - 10M mode: a counter clears when registered CRS_DV rises in IDLE and counts 0..DIV_10M-1 with wrap. The strobe fires at count DIV_10M/2-1.
  - FSM, assembly and CRC advance only on strobe.
- FSM states:
  - IDLE: CRS_DV=1 -> PREAMBLE.
  - PREAMBLE: 00 stay; 01 -> SFD; 10/11 -> ERROR.
  - SFD: 01 stay; 11 -> DATA; 00/10 -> ERROR.
  - DATA: CRS_DV=1 shifts RXD in LSB-first (4 dibits/byte). CRS_DV=0 -> end of frame -> IDLE.
  - DROP: wait for CRS_DV=0 -> IDLE.
  - ERROR: wait for CRS_DV=0 -> IDLE. Emits no beats and no pulses.
  - Carrier loss (CRS_DV=0) in PREAMBLE/SFD -> IDLE.
- Packing:
  - Completed bytes fill a word from lane 0 upward.
  - A full word is held in a pending register. It is pushed with TLAST=0 when the next byte of the frame completes.
  - At end of frame the pending/partial word is pushed with TLAST=1, TKEEP=filled lanes, TUSER=status.
- Status (TUSER=1 if any of):
  - CRC-32 residue is not 0xDEBB20E3. CRC is reflected (poly 0xEDB88320), init 0xFFFFFFFF, over all bytes after SFD including FCS.
  - Byte count < MIN_FRAME. Byte count is a 16-bit saturating counter.
  - Dibit count is not a multiple of 4. The partial byte is discarded.
- Status pulse: o_frame_ok or o_frame_err pulses in the cycle the final beat is pushed.
- Zero-byte frame (SFD then carrier loss): no beats; o_frame_err pulses.
- FIFO behaviour:
  - FIFO slot DEPTH-1 is reserved for terminators. Non-final pushes are allowed only while count < FIFO_DEPTH-1.
  - A non-final push at count = FIFO_DEPTH-1 instead pushes the pending word as TLAST=1, TUSER=1. o_overflow and o_frame_err pulse, and the FSM goes to DROP.
  - A final beat always fits. A new frame with count = FIFO_DEPTH-1 overflows on its first push.
- Push and pop in the same cycle: count unchanged.
- AXIS handshake:
  - Beats transfer on TVALID & TREADY.
  - While TVALID=1 and TREADY=0, TDATA/TKEEP/TLAST/TUSER are held stable and TVALID stays high.
  - TVALID is driven by FIFO non-empty. The outputs are FIFO-registered, with no combinational path from TREADY.
- Latency: a beat pushed at edge N has TVALID high after edge N+1 if the FIFO was empty. The push occurs one cycle after the strobe that completes the triggering byte or detects carrier loss.

Test Plan:
- DATA_WIDTH=32, 100M, 7x55 + D5 preamble/SFD, 64-byte frame with valid FCS, TREADY=1 -> 16 beats, TKEEP=4'hF, TLAST only on beat 16, TUSER=0, one o_frame_ok.
- DATA_WIDTH=32, 65-byte valid frame -> 17 beats, last TKEEP=4'b0001, TLAST=1, TUSER=0; then the same frame with the last FCS byte bit-flipped -> TUSER=1, o_frame_err.
- DATA_WIDTH=8, 10M mode, 64-byte valid frame, each dibit held 10 cycles -> 64 beats identical to the 100M run, o_frame_ok.
- DATA_WIDTH=8, FIFO_DEPTH=16, TREADY=0, 100-byte frame -> o_overflow once; after TREADY=1, 16 beats, beat 16 TLAST=1 TUSER=1; next good frame passes clean.
- Preamble containing dibit 10 -> no beats, no pulses. 60-byte frame with valid FCS -> TUSER=1 (runt). Frame with 2 extra dibits -> TUSER=1 (alignment).
- Assert reset for 1 cycle mid-frame with 3 beats queued -> TVALID=0 next cycle; frame in progress ignored until CRS_DV is sampled low; next frame received correctly.

Source files
------------

// File: rtl/sakebi_rmii_rx_stream.sv
// RMII receiver in the REF_CLK domain: strips preamble/SFD, packs bytes into an
// AXI-Stream, checks FCS/length/alignment and buffers beats in an output FIFO.
module sakebi_rmii_rx_stream #(
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int MIN_FRAME  = 64,
   parameter int DIV_10M    = 10
) (
   input  logic                    i_rmii_REF_CLK,
   input  logic                    i_rmii_RESET,
   input  logic                    i_speed_100,
   input  logic                    i_rmii_CRS_DV,
   input  logic [1:0]              i_rmii_RXD,
   output logic                    o_axis_TVALID,
   input  logic                    i_axis_TREADY,
   output logic [DATA_WIDTH-1:0]   o_axis_TDATA,
   output logic [DATA_WIDTH/8-1:0] o_axis_TKEEP,
   output logic                    o_axis_TLAST,
   output logic                    o_axis_TUSER,
   output logic                    o_frame_ok,
   output logic                    o_frame_err,
   output logic                    o_overflow
);

   localparam int NB  = DATA_WIDTH / 8;
   localparam int ACW = $clog2(NB + 1);
   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int CW  = AW + 2;
   localparam int DCW = (DIV_10M > 1) ? $clog2(DIV_10M) : 1;
   localparam int EW  = DATA_WIDTH + NB + 2;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PREAMBLE = 3'd1;
   localparam logic [2:0] ST_SFD      = 3'd2;
   localparam logic [2:0] ST_DATA     = 3'd3;
   localparam logic [2:0] ST_DROP     = 3'd4;
   localparam logic [2:0] ST_ERROR    = 3'd5;

   localparam logic [CW-1:0]  NONFINAL_LIM = CW'(FIFO_DEPTH - 1);
   localparam logic [AW:0]    MEM_FULL     = (AW + 1)'(FIFO_DEPTH);
   localparam logic [DCW-1:0] DIV_LAST     = DCW'(DIV_10M - 1);
   localparam logic [DCW-1:0] DIV_MID      = DCW'(DIV_10M / 2 - 1);

   function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int i = 0; i < 8; i++)
         r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   function automatic logic [NB-1:0] fill_keep(input logic [ACW-1:0] n);
      logic [NB-1:0] k;
      for (int i = 0; i < NB; i++)
         k[i] = (ACW'(i) < n);
      return k;
   endfunction

   logic                  crs_q, crs_prev, armed, strobe, rise_idle;
   logic [1:0]            rxd_q, dibit_cnt;
   logic [2:0]            state;
   logic [DCW-1:0]        div_cnt;
   logic [7:0]            sr, next_sr, new_byte;
   logic                  byte_done, eof, misalign, frame_bad;
   logic [31:0]           crc;
   logic [15:0]           byte_cnt;
   logic [DATA_WIDTH-1:0] acc;
   logic [ACW-1:0]        acc_cnt;
   logic                  push, mem_wr, load, ovf_now, ok_now, err_now, push_last, push_user;
   logic [NB-1:0]         push_keep;
   logic [EW-1:0]         mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr, rd_ptr;
   logic [AW:0]           mem_count;
   logic [CW-1:0]         fifo_count;

   // Input capture is left unreset so the first sample after reset is genuine.
   always_ff @(posedge i_rmii_REF_CLK) begin
      crs_q    <= i_rmii_CRS_DV;
      crs_prev <= crs_q;
      rxd_q    <= i_rmii_RXD;
   end

   assign rise_idle = (state == ST_IDLE) && crs_q && !crs_prev;
   assign strobe    = i_speed_100 ? 1'b1 : (!rise_idle && div_cnt == DIV_MID);
   assign next_sr   = {rxd_q, sr[7:2]};

   always_ff @(posedge i_rmii_REF_CLK) begin
      if (i_rmii_RESET || rise_idle || div_cnt == DIV_LAST)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DCW'(1);
   end

   always_ff @(posedge i_rmii_REF_CLK) begin
      if (i_rmii_RESET) begin
         state     <= ST_IDLE;
         armed     <= 1'b0;
         sr        <= '0;
         dibit_cnt <= '0;
         byte_done <= 1'b0;
         new_byte  <= '0;
         eof       <= 1'b0;
         misalign  <= 1'b0;
         crc       <= '1;
         byte_cnt  <= '0;
      end else begin
         byte_done <= 1'b0;
         eof       <= 1'b0;
         if (!crs_q)
            armed <= 1'b1;
         // An overflow abandons the frame even between strobes.
         if (ovf_now)
            state <= ST_DROP;
         else if (strobe) begin
            case (state)
               ST_IDLE:
                  if (crs_q && armed) state <= ST_PREAMBLE;
               ST_PREAMBLE:
                  if (!crs_q) state <= ST_IDLE;
                  else if (rxd_q == 2'b01) state <= ST_SFD;
                  else if (rxd_q != 2'b00) state <= ST_ERROR;
               ST_SFD:
                  if (!crs_q) state <= ST_IDLE;
                  else if (rxd_q == 2'b11) begin
                     state     <= ST_DATA;
                     dibit_cnt <= '0;
                     crc       <= '1;
                     byte_cnt  <= '0;
                  end else if (rxd_q != 2'b01) state <= ST_ERROR;
               ST_DATA:
                  if (!crs_q) begin
                     state    <= ST_IDLE;
                     eof      <= 1'b1;
                     misalign <= (dibit_cnt != 2'd0);
                  end else begin
                     sr        <= next_sr;
                     dibit_cnt <= dibit_cnt + 2'd1;
                     if (dibit_cnt == 2'd3) begin
                        byte_done <= 1'b1;
                        new_byte  <= next_sr;
                        crc       <= crc_next(crc, next_sr);
                        if (byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 16'd1;
                     end
                  end
               ST_DROP, ST_ERROR:
                  if (!crs_q) state <= ST_IDLE;
               default:
                  state <= ST_IDLE;
            endcase
         end
      end
   end

   assign fifo_count = CW'(mem_count) + CW'(o_axis_TVALID);
   assign frame_bad  = (crc != 32'hDEBB20E3) || (byte_cnt < 16'(MIN_FRAME)) || misalign;

   // A full pending word is only released when the frame proves it has more bytes.
   always_comb begin
      push      = 1'b0;
      push_last = 1'b0;
      push_user = 1'b0;
      push_keep = fill_keep(acc_cnt);
      ovf_now   = 1'b0;
      ok_now    = 1'b0;
      err_now   = 1'b0;
      if (byte_done) begin
         if (acc_cnt == ACW'(NB)) begin
            push = 1'b1;
            if (fifo_count >= NONFINAL_LIM) begin
               push_last = 1'b1;
               push_user = 1'b1;
               ovf_now   = 1'b1;
               err_now   = 1'b1;
            end
         end
      end else if (eof) begin
         if (acc_cnt == '0)
            err_now = 1'b1;
         else begin
            push      = 1'b1;
            push_last = 1'b1;
            push_user = frame_bad;
            ok_now    = !frame_bad;
            err_now   = frame_bad;
         end
      end
   end

   assign mem_wr = push && (mem_count != MEM_FULL);
   assign load   = (mem_count != '0) && (!o_axis_TVALID || i_axis_TREADY);

   always_ff @(posedge i_rmii_REF_CLK) begin
      if (i_rmii_RESET) begin
         acc     <= '0;
         acc_cnt <= '0;
      end else if (byte_done) begin
         if (acc_cnt == ACW'(NB)) begin
            acc     <= ovf_now ? '0 : DATA_WIDTH'(new_byte);
            acc_cnt <= ovf_now ? '0 : ACW'(1);
         end else begin
            for (int i = 0; i < NB; i++)
               if (acc_cnt == ACW'(i)) acc[8*i +: 8] <= new_byte;
            acc_cnt <= acc_cnt + ACW'(1);
         end
      end else if (eof) begin
         acc     <= '0;
         acc_cnt <= '0;
      end
   end

   always_ff @(posedge i_rmii_REF_CLK) begin
      if (mem_wr)
         mem[wr_ptr] <= {push_user, push_last, push_keep, acc};
   end

   // The head beat lives in the output register, so TVALID counts as a FIFO entry.
   always_ff @(posedge i_rmii_REF_CLK) begin
      if (i_rmii_RESET) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         mem_count     <= '0;
         o_axis_TVALID <= 1'b0;
         o_axis_TDATA  <= '0;
         o_axis_TKEEP  <= '0;
         o_axis_TLAST  <= 1'b0;
         o_axis_TUSER  <= 1'b0;
         o_frame_ok    <= 1'b0;
         o_frame_err   <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         o_frame_ok  <= ok_now;
         o_frame_err <= err_now;
         o_overflow  <= ovf_now;
         if (mem_wr)
            wr_ptr <= wr_ptr + AW'(1);
         if (load) begin
            {o_axis_TUSER, o_axis_TLAST, o_axis_TKEEP, o_axis_TDATA} <= mem[rd_ptr];
            rd_ptr        <= rd_ptr + AW'(1);
            o_axis_TVALID <= 1'b1;
         end else if (i_axis_TREADY)
            o_axis_TVALID <= 1'b0;
         case ({mem_wr, load})
            2'b10:   mem_count <= mem_count + (AW + 1)'(1);
            2'b01:   mem_count <= mem_count - (AW + 1)'(1);
            default: mem_count <= mem_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sakebi_rmii_rx_stream.sv
// Scoreboard bench for sakebi_rmii_rx_stream at 32-bit width: directed RMII
// frames push expected beats, a negedge monitor pops and compares them.
module tb_sakebi_rmii_rx_stream;

   localparam int NB = 4;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        speed_100 = 1'b1;
   logic        crs_dv = 1'b0;
   logic [1:0]  rxd = 2'b00;
   logic        tready = 1'b1;
   logic        tvalid, tlast, tuser, frame_ok, frame_err, overflow;
   logic [31:0] tdata;
   logic [3:0]  tkeep;

   beat_t       sb[$];
   logic [7:0]  frame_q[$];
   int          n_tests = 0, n_fail = 0, beat_no = 0;
   int          cnt_ok = 0, cnt_err = 0, cnt_ovf = 0;
   int          exp_ok = 0, exp_err = 0, exp_ovf = 0;
   int          hold = 1;
   beat_t       held, exp_b;
   logic        stall = 1'b0;
   logic [31:0] mask;

   always #10 clk = ~clk;

   sakebi_rmii_rx_stream #(
      .DATA_WIDTH(32),
      .FIFO_DEPTH(16),
      .MIN_FRAME (64),
      .DIV_10M   (10)
   ) dut (
      .i_rmii_REF_CLK(clk),
      .i_rmii_RESET  (rst),
      .i_speed_100   (speed_100),
      .i_rmii_CRS_DV (crs_dv),
      .i_rmii_RXD    (rxd),
      .o_axis_TVALID (tvalid),
      .i_axis_TREADY (tready),
      .o_axis_TDATA  (tdata),
      .o_axis_TKEEP  (tkeep),
      .o_axis_TLAST  (tlast),
      .o_axis_TUSER  (tuser),
      .o_frame_ok    (frame_ok),
      .o_frame_err   (frame_err),
      .o_overflow    (overflow)
   );

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
      logic [31:0] r;
      r = c ^ {24'h0, b};
      for (int k = 0; k < 8; k++)
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      return r;
   endfunction

   // Payload bytes followed by the FCS, least significant byte first.
   task automatic build_frame(input int payload_len, input int seed);
      logic [31:0] c;
      logic [7:0]  b;
      frame_q.delete();
      c = 32'hFFFFFFFF;
      for (int i = 0; i < payload_len; i++) begin
         b = 8'((i * 7 + seed * 13) & 255);
         frame_q.push_back(b);
         c = crc_byte(c, b);
      end
      c = ~c;
      for (int k = 0; k < 4; k++) frame_q.push_back(c[8*k +: 8]);
   endtask

   task automatic expect_frame(input int n, input logic user);
      beat_t bt;
      int    lane;
      bt   = '0;
      lane = 0;
      for (int i = 0; i < n; i++) begin
         bt.data[8*lane +: 8] = frame_q[i];
         bt.keep[lane] = 1'b1;
         lane++;
         if (lane == NB || i == n - 1) begin
            bt.last = (i == n - 1);
            bt.user = (i == n - 1) ? user : 1'b0;
            sb.push_back(bt);
            bt   = '0;
            lane = 0;
         end
      end
   endtask

   task automatic drive_dibit(input logic c, input logic [1:0] d);
      crs_dv = c;
      rxd    = d;
      repeat (hold) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int k = 0; k < 4; k++) drive_dibit(1'b1, b[2*k +: 2]);
   endtask

   task automatic send_preamble();
      for (int i = 0; i < 7; i++) send_byte(8'h55);
      send_byte(8'hD5);
   endtask

   task automatic idle_gap(input int n);
      crs_dv = 1'b0;
      rxd    = 2'b00;
      repeat (n * hold) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int extra_dibits);
      send_preamble();
      foreach (frame_q[i]) send_byte(frame_q[i]);
      for (int k = 0; k < extra_dibits; k++) drive_dibit(1'b1, 2'b10);
      idle_gap(24);
   endtask

   task automatic check_eq(input string name, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
      end
   endtask

   task automatic wait_drain(input string name);
      int c;
      c = 0;
      while ((sb.size() != 0 || tvalid) && c < 2000) begin
         @(negedge clk);
         c++;
      end
      n_tests++;
      if (c >= 2000) begin
         n_fail++;
         $display("[TB] FAIL %s drain: got %0d beats pending, want 0", name, sb.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name);
      check_eq({name, " ok pulses"}, cnt_ok, exp_ok);
      check_eq({name, " err pulses"}, cnt_err, exp_err);
      check_eq({name, " overflow pulses"}, cnt_ovf, exp_ovf);
      check_eq({name, " beats outstanding"}, sb.size(), 0);
   endtask

   // Monitor: counts pulses, checks stall stability and pops the scoreboard.
   always @(negedge clk) begin
      if (frame_ok)  cnt_ok++;
      if (frame_err) cnt_err++;
      if (overflow)  cnt_ovf++;
      if (rst)
         stall = 1'b0;
      else begin
         if (stall) begin
            n_tests++;
            if (!tvalid || {tdata, tkeep, tlast, tuser} != held) begin
               n_fail++;
               $display("[TB] FAIL stall hold: got valid=%b data=%h, want valid=1 data=%h",
                        tvalid, tdata, held.data);
            end
         end
         if (tvalid && tready) begin
            beat_no++;
            n_tests++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("[TB] FAIL unexpected beat %0d: got data=%h last=%b, want no beat",
                        beat_no, tdata, tlast);
            end else begin
               exp_b = sb.pop_front();
               for (int l = 0; l < NB; l++) mask[8*l +: 8] = {8{exp_b.keep[l]}};
               if (((tdata ^ exp_b.data) & mask) != 32'h0 || tkeep != exp_b.keep ||
                   tlast != exp_b.last || tuser != exp_b.user) begin
                  n_fail++;
                  $display("[TB] FAIL beat %0d: got data=%h keep=%h last=%b user=%b, want data=%h keep=%h last=%b user=%b",
                           beat_no, tdata, tkeep, tlast, tuser,
                           exp_b.data, exp_b.keep, exp_b.last, exp_b.user);
               end
            end
         end
         stall = tvalid && !tready;
         held  = {tdata, tkeep, tlast, tuser};
      end
   end

   initial begin
      #800000;
      n_fail++;
      $display("[TB] FAIL watchdog: got no completion, want completion");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_eq("reset tvalid", tvalid, 0);
      check_eq("reset tlast", tlast, 0);
      check_eq("reset tkeep", tkeep, 0);
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      build_frame(60, 1);
      expect_frame(64, 1'b0);
      applyStimulus(0);
      wait_drain("good64");
      exp_ok++;
      checkOutput("good64");

      build_frame(61, 2);
      expect_frame(65, 1'b0);
      applyStimulus(0);
      wait_drain("good65");
      exp_ok++;
      checkOutput("good65");

      build_frame(61, 2);
      frame_q[64] = frame_q[64] ^ 8'h01;
      expect_frame(65, 1'b1);
      applyStimulus(0);
      wait_drain("badfcs");
      exp_err++;
      checkOutput("badfcs");

      speed_100 = 1'b0;
      hold      = 10;
      build_frame(60, 1);
      expect_frame(64, 1'b0);
      applyStimulus(0);
      wait_drain("10m");
      exp_ok++;
      checkOutput("10m");
      speed_100 = 1'b1;
      hold      = 1;
      idle_gap(4);

      tready = 1'b0;
      build_frame(96, 3);
      expect_frame(64, 1'b1);
      applyStimulus(0);
      check_eq("overflow while stalled", cnt_ovf, 1);
      tready = 1'b1;
      wait_drain("overflow");
      exp_ovf++;
      exp_err++;
      checkOutput("overflow");
      build_frame(60, 4);
      expect_frame(64, 1'b0);
      applyStimulus(0);
      wait_drain("after overflow");
      exp_ok++;
      checkOutput("after overflow");

      for (int i = 0; i < 4; i++) drive_dibit(1'b1, 2'b01);
      drive_dibit(1'b1, 2'b10);
      send_preamble();
      for (int i = 0; i < 8; i++) send_byte(8'hA5);
      idle_gap(24);
      check_eq("bad preamble tvalid", tvalid, 0);
      checkOutput("bad preamble");

      build_frame(56, 5);
      expect_frame(60, 1'b1);
      applyStimulus(0);
      wait_drain("runt");
      exp_err++;
      checkOutput("runt");

      build_frame(60, 6);
      expect_frame(64, 1'b1);
      applyStimulus(2);
      wait_drain("align");
      exp_err++;
      checkOutput("align");

      send_preamble();
      idle_gap(24);
      exp_err++;
      checkOutput("zero byte");

      tready = 1'b0;
      build_frame(60, 7);
      send_preamble();
      for (int i = 0; i < 16; i++) send_byte(frame_q[i]);
      check_eq("pre-reset tvalid", tvalid, 1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      tready = 1'b1;
      @(negedge clk);
      check_eq("post-reset tvalid", tvalid, 0);
      @(posedge clk);
      #1;
      for (int i = 16; i < 64; i++) send_byte(frame_q[i]);
      idle_gap(24);
      checkOutput("reset ignored");
      build_frame(60, 8);
      expect_frame(64, 1'b0);
      applyStimulus(0);
      wait_drain("after reset");
      exp_ok++;
      checkOutput("after reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
